// File: rtl/freq_meter.sv
// Gated edge counter: counts synchronised rising edges of sig_in over a window of
// CLK_IN/GATE_HZ clock cycles and publishes the saturating count with a valid strobe.
module freq_meter #(
  parameter int CLK_IN  = 48_000_000,
  parameter int GATE_HZ = 1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic             overflow
);

  localparam int GATE_CYC = CLK_IN / GATE_HZ;
  localparam int GATE_W   = (GATE_CYC > 2) ? $clog2(GATE_CYC) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYC - 1);

  generate
    if (GATE_CYC < 2) begin : g_gate_check
      $error("freq_meter: GATE_CYC = CLK_IN/GATE_HZ must be at least 2");
    end
  endgenerate

  // Saturating increment; the MSB of the result flags an increment refused at all-ones.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] val, input logic inc);
    if (!inc) begin
      sat_inc = {1'b0, val};
    end else if (&val) begin
      sat_inc = {1'b1, val};
    end else begin
      sat_inc = {1'b0, val + CNT_W'(1)};
    end
  endfunction

  logic              s1_r, s2_r, s3_r;
  logic [GATE_W-1:0] gate_cnt_r;
  logic [CNT_W-1:0]  edge_cnt_r;
  logic              sat_r;
  logic              rise_s;
  logic [CNT_W-1:0]  edge_next_s;
  logic              sat_hit_s;

  assign rise_s = s2_r & ~s3_r;

  // Next edge count including any rise in the current cycle.
  always_comb begin
    {sat_hit_s, edge_next_s} = sat_inc(edge_cnt_r, rise_s);
  end

  // Synchroniser and history stages reset high so a high input gives no edge at release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r <= 1'b1;
      s2_r <= 1'b1;
      s3_r <= 1'b1;
    end else begin
      s1_r <= sig_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // Gate timing, edge accumulation and result publication at window close.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_cnt_r <= {GATE_W{1'b0}};
      edge_cnt_r <= {CNT_W{1'b0}};
      sat_r      <= 1'b0;
      count      <= {CNT_W{1'b0}};
      valid      <= 1'b0;
      overflow   <= 1'b0;
    end else if (gate_cnt_r == GATE_LAST) begin
      // A rise in the closing cycle still belongs to the closing window.
      gate_cnt_r <= {GATE_W{1'b0}};
      edge_cnt_r <= {CNT_W{1'b0}};
      sat_r      <= 1'b0;
      count      <= edge_next_s;
      overflow   <= sat_r | sat_hit_s;
      valid      <= 1'b1;
    end else begin
      gate_cnt_r <= gate_cnt_r + GATE_W'(1);
      edge_cnt_r <= edge_next_s;
      sat_r      <= sat_r | sat_hit_s;
      valid      <= 1'b0;
    end
  end

endmodule
